// File: rtl/seq_trial_divider.sv
// Iterative restoring divider: one quotient bit per clock, start/busy/done handshake.
// Define SEQ_TRIAL_DIVIDER_EARLY_EXIT_EN to finish immediately when dividend < divisor.
module seq_trial_divider #(
  parameter int SIZE = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [SIZE-1:0] dividend,
  input  logic [SIZE-1:0] divisor,
  output logic            busy,
  output logic            done,
  output logic            div_by_zero,
  output logic [SIZE-1:0] quotient,
  output logic [SIZE-1:0] remainder
);

  localparam int CW = $clog2(SIZE + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t          state_reg;
  logic [SIZE-1:0] q_reg;
  logic [SIZE-1:0] d_reg;
  logic [SIZE-1:0] r_reg;
  logic [CW-1:0]   count_reg;

  logic [SIZE:0]   t;
  logic [SIZE:0]   diff;
  logic            ge;
  logic [SIZE-1:0] r_next;
  logic [SIZE-1:0] q_next;
  logic            accept;
  logic            fast_exit;

  // R < D always holds between steps, so T < 2D and T-D fits in SIZE bits;
  // the top bit of the SIZE+1-bit difference is therefore a clean borrow flag.
  always_comb begin
    t      = {r_reg, q_reg[SIZE-1]};
    diff   = t - {1'b0, d_reg};
    ge     = ~diff[SIZE];
    r_next = ge ? diff[SIZE-1:0] : t[SIZE-1:0];
    q_next = {q_reg[SIZE-2:0], ge};
    accept = start && (state_reg != CALC);
  end

`ifdef SEQ_TRIAL_DIVIDER_EARLY_EXIT_EN
  assign fast_exit = (dividend < divisor);
`else
  assign fast_exit = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      q_reg       <= '0;
      d_reg       <= '0;
      r_reg       <= '0;
      count_reg   <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
    end else begin
      case (state_reg)
        IDLE, DONE: begin
          done <= 1'b0;
          busy <= 1'b0;
          if (accept) begin
            q_reg     <= dividend;
            d_reg     <= divisor;
            r_reg     <= '0;
            count_reg <= CW'(SIZE);
            if (divisor == '0) begin
              state_reg   <= DONE;
              done        <= 1'b1;
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
            end else if (fast_exit) begin
              state_reg   <= DONE;
              done        <= 1'b1;
              quotient    <= '0;
              remainder   <= dividend;
              div_by_zero <= 1'b0;
            end else begin
              state_reg <= CALC;
              busy      <= 1'b1;
            end
          end else begin
            state_reg <= IDLE;
          end
        end
        CALC: begin
          r_reg     <= r_next;
          q_reg     <= q_next;
          count_reg <= count_reg - CW'(1);
          if (count_reg == CW'(1)) begin
            state_reg   <= DONE;
            busy        <= 1'b0;
            done        <= 1'b1;
            quotient    <= q_next;
            remainder   <= r_next;
            div_by_zero <= 1'b0;
          end
        end
        default: begin
          state_reg <= IDLE;
          busy      <= 1'b0;
          done      <= 1'b0;
        end
      endcase
    end
  end

endmodule
